// File: rtl/jt49_env_step.sv
// jt49_env_step: envelope step engine driven by divider toggles, producing a 5-bit level and an end-of-cycle pulse
// Ports: clk, rst (sync, active-high), cen (clock enable), step (divider output, each change is one step),
//        shape {CONT,ATT,ALT,HOLD}, restart (shape write pulse), env (level 0..31), eoc (end-of-cycle pulse).
// Macro JT49_ENV_32STEP_EN: 32 steps of 1 per cycle; when undefined, 16 steps of 2 per cycle.
module jt49_env_step (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       step,
    input  logic [3:0] shape,
    input  logic       restart,
    output logic [4:0] env,
    output logic       eoc
);
`ifdef JT49_ENV_32STEP_EN
    localparam logic [4:0] inc = 5'd1, last = 5'd31;
`else
    localparam logic [4:0] inc = 5'd2, last = 5'd30;
`endif
    logic [4:0] cnt_q, cnt_d, env_q, env_d, base;
    logic       inv_q, inv_d, stop_q, stop_d, zero_q, zero_d;
    logic       step_l_q, step_l_d, eoc_q, eoc_d;
    logic       cont, att, alt, hold, ev;
    always_comb begin
        {cont, att, alt, hold} = shape;
        ev       = cen && (step != step_l_q) && !stop_q;
        step_l_d = cen ? step : step_l_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        stop_d   = stop_q;
        zero_d   = zero_q;
        eoc_d    = 1'b0;
        if (restart) begin
            cnt_d  = 5'd0;
            inv_d  = 1'b0;
            stop_d = 1'b0;
            zero_d = 1'b0;
        end else if (ev) begin
            if (cnt_q != last) begin
                cnt_d = cnt_q + inc;
            end else begin
                eoc_d = 1'b1;
                if (!cont) begin
                    stop_d = 1'b1;
                    zero_d = 1'b1;
                end else if (hold) begin
                    stop_d = 1'b1;
                end else begin
                    cnt_d = 5'd0;
                    inv_d = inv_q ^ alt;
                end
            end
        end
        base  = att ? cnt_q : 5'd31 - cnt_q;
        env_d = zero_q ? 5'd0 : stop_q ? {5{att ^ alt}} : inv_q ? 5'd31 - base : base;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            inv_q    <= 1'b0;
            stop_q   <= 1'b1;
            zero_q   <= 1'b1;
            step_l_q <= 1'b0;
            eoc_q    <= 1'b0;
            env_q    <= 5'd0;
        end else begin
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
            stop_q   <= stop_d;
            zero_q   <= zero_d;
            step_l_q <= step_l_d;
            eoc_q    <= eoc_d;
            env_q    <= env_d;
        end
    end
    assign env = env_q;
    assign eoc = eoc_q;
endmodule

// File: tb/tb_jt49_env_step.sv
// tb_jt49_env_step: scoreboard bench for jt49_env_step against a step-count envelope model
module tb_jt49_env_step;
    logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, step = 1'b0, restart = 1'b0;
    logic [3:0] shape = 4'd0;
    logic [4:0] env;
    logic       eoc;
`ifdef JT49_ENV_32STEP_EN
    localparam int INC = 1, N = 32;
`else
    localparam int INC = 2, N = 16;
`endif
    typedef struct {
        logic [4:0] env;
        logic       eoc;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    // model: position within the current cycle, which half of an alternating pattern, idle/hold flags
    bit m_zero = 1, m_hold = 1, m_phase = 0, m_stl = 0;
    int m_pos = 0;

    jt49_env_step dut (
        .clk(clk), .rst(rst), .cen(cen), .step(step),
        .shape(shape), .restart(restart), .env(env), .eoc(eoc)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] level(input logic [3:0] sh);
        int v;
        if (m_zero) return 5'd0;
        if (m_hold) return (sh[2] ^ sh[1]) ? 5'd31 : 5'd0;
        v = m_pos * INC;
        return (sh[2] ^ m_phase) ? 5'(v) : 5'(31 - v);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e.env = level(shape);
        e.eoc = 1'b0;
        if (rst) begin
            e.env = 5'd0;
            m_zero = 1; m_hold = 1; m_phase = 0; m_pos = 0; m_stl = 0;
        end else if (restart) begin
            m_zero = 0; m_hold = 0; m_phase = 0; m_pos = 0;
            if (cen) m_stl = step;
        end else if (cen) begin
            if (step != m_stl && !m_hold) begin
                if (m_pos == N - 1) begin
                    e.eoc = 1'b1;
                    if (!shape[3]) begin
                        m_hold = 1; m_zero = 1;
                    end else if (shape[0]) begin
                        m_hold = 1;
                    end else begin
                        m_pos = 0;
                        if (shape[1]) m_phase = ~m_phase;
                    end
                end else begin
                    m_pos++;
                end
            end
            m_stl = step;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (env !== e.env || eoc !== e.eoc) begin
                errors++;
                $display("FAIL env_eoc t=%0t: got env=%0d eoc=%b, want env=%0d eoc=%b",
                         $time, env, eoc, e.env, e.eoc);
            end
        end
    end

    task automatic cyc(input bit c, input bit r);
        cen = c;
        restart = r;
        @(negedge clk);
    endtask

    task automatic steps(input int n, input bit c = 1);
        repeat (n) begin
            step = ~step;
            cyc(c, 0);
            cyc(c, 0);
        end
    endtask

    task automatic rs(input logic [3:0] sh);
        shape = sh;
        cyc(1, 1);
        cyc(1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        steps(8);
        rs(4'b1101); steps(N + 4);
        rs(4'b1110); steps(2 * N + 4);
        rs(4'b0000); steps(N + 4);
        rs(4'b1100); steps(10);
        step = ~step;
        cyc(1, 1);
        steps(5);
        steps(6, 0);
        steps(3);
        rs(4'b1011); steps(N + 3);
        repeat (1500) begin
            if ($urandom_range(0, 40) == 0) shape = 4'($urandom);
            if ($urandom_range(0, 1) == 1) step = ~step;
            rst = ($urandom_range(0, 400) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);
        end
        rst = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        checks++;
        if (q.size() > 1) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want at most 1", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
